// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty ramp controller and its period counter.
package pwm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_e;

  localparam int DEFAULT_W            = 4;
  localparam int DEFAULT_STEP_PERIODS = 4;

endpackage

// File: rtl/pwm_period_cnt.sv
// Free-running PWM period counter: 2^W cycles per period, with wrap and a
// registered period_start pulse on the first cycle of every new period.
module pwm_period_cnt
  import pwm_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         period_start
);

  logic [W-1:0] count_q, count_d;
  logic         period_start_q, period_start_d;

  always_comb begin
    wrap           = enable && (count_q == '1);
    count_d        = enable ? count_q + 1'b1 : count_q;
    period_start_d = wrap;
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      count_q        <= '0;
      period_start_q <= 1'b0;
    end else begin
      count_q        <= count_d;
      period_start_q <= period_start_d;
    end
  end

  assign count        = count_q;
  assign period_start = period_start_q;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Accepts a target duty and walks duty_out toward it one LSB every
// STEP_PERIODS PWM periods, so each PWM period always uses a constant duty.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int W            = DEFAULT_W,
  parameter int STEP_PERIODS = DEFAULT_STEP_PERIODS
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         enable,
  input  logic         tgt_valid,
  input  logic [W-1:0] tgt_duty,
  output logic         tgt_ready,
  input  logic         abort,
  output logic [W-1:0] duty_out,
  output logic         period_start,
  output logic         busy,
  output logic         done
);

  localparam logic [7:0] STEP_LAST = 8'(STEP_PERIODS - 1);

  ramp_state_e  state_q, state_d;
  logic [W-1:0] duty_q, duty_d;
  logic [W-1:0] target_q, target_d;
  logic [7:0]   step_q, step_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [W-1:0] period_count;
  logic         wrap;
  logic         transfer;
  logic [W-1:0] duty_toward;

  pwm_period_cnt #(.W(W)) u_period_cnt (
    .clk_in       (clk_in),
    .rst          (rst),
    .enable       (enable),
    .count        (period_count),
    .wrap         (wrap),
    .period_start (period_start)
  );

  assign tgt_ready   = (state_q == IDLE);
  assign transfer    = tgt_valid && tgt_ready;
  // In RAMP the target always differs from duty_q, so this never wraps.
  assign duty_toward = (target_q > duty_q) ? duty_q + 1'b1 : duty_q - 1'b1;

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    step_d   = step_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (transfer) begin
          target_d = tgt_duty;
          step_d   = '0;
          if (tgt_duty == duty_q) begin
            done_d = 1'b1;
          end else begin
            state_d = RAMP;
            busy_d  = 1'b1;
          end
        end
      end
      RAMP: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (wrap) begin
          if (step_q == STEP_LAST) begin
            step_d = '0;
            duty_d = duty_toward;
            if (duty_toward == target_q) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            step_d = step_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      target_q <= '0;
      step_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      step_q   <= step_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign duty_out = duty_q;
  assign busy     = busy_q;
  assign done     = done_q;

  period_start_at_zero: assert property (
    @(posedge clk_in) disable iff (!rst) period_start |-> (period_count == '0)
  );

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl (W=4, STEP_PERIODS=2): stimulus queues
// expected duty/done events, a negedge monitor pops them as the DUT produces them.
module tb_pwm_ramp_ctrl;

  localparam int W  = 4;
  localparam int SP = 2;

  logic         clk_in = 1'b0;
  logic         rst = 1'b0;
  logic         enable = 1'b0;
  logic         tgt_valid = 1'b0;
  logic [W-1:0] tgt_duty = '0;
  logic         tgt_ready;
  logic         abort = 1'b0;
  logic [W-1:0] duty_out;
  logic         period_start;
  logic         busy;
  logic         done;

  typedef struct {
    int duty;
    int done;
    int busy;
    int wrap;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   wrap_cnt = 0;
  int   en_cycles = 0;
  int   last_ps = -1;
  int   last_duty = 0;
  int   model_duty = 0;

  pwm_ramp_ctrl #(.W(W), .STEP_PERIODS(SP)) dut (
    .clk_in       (clk_in),
    .rst          (rst),
    .enable       (enable),
    .tgt_valid    (tgt_valid),
    .tgt_duty     (tgt_duty),
    .tgt_ready    (tgt_ready),
    .abort        (abort),
    .duty_out     (duty_out),
    .period_start (period_start),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  always @(posedge clk_in) begin
    if (rst && enable) en_cycles++;
  end

  // Monitor: every duty change or done pulse must match the head of the scoreboard.
  always @(negedge clk_in) begin
    if (!rst) begin
      last_duty = 0;
      last_ps   = -1;
    end else begin
      if (period_start) begin
        wrap_cnt++;
        if (last_ps >= 0) checkOutput("period_spacing", en_cycles - last_ps, 16);
        last_ps = en_cycles;
      end
      if ((int'(duty_out) != last_duty) || done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_event_duty", int'(duty_out), last_duty);
          checkOutput("unexpected_event_done", int'(done), 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("event_duty", int'(duty_out), e.duty);
          checkOutput("event_done", int'(done), e.done);
          checkOutput("event_busy", int'(busy), e.busy);
          checkOutput("event_wrap", wrap_cnt, e.wrap);
        end
      end
      last_duty = int'(duty_out);
    end
  end

  task automatic syncMidPeriod();
    int i = 0;
    do begin
      @(negedge clk_in);
      i++;
    end while (!period_start && i < 40);
    if (!period_start) checkOutput("period_start_timeout", 0, 1);
    repeat (3) @(negedge clk_in);
    #1;
  endtask

  // Issue one transfer mid-period and queue up to n_push expected step events.
  task automatic applyStimulus(input int target, input int n_push);
    int base;
    int diff;
    int dir;
    int n;
    exp_t e;
    syncMidPeriod();
    base = wrap_cnt;
    diff = (target > model_duty) ? target - model_duty : model_duty - target;
    dir  = (target > model_duty) ? 1 : -1;
    if (diff == 0) begin
      e = '{duty: model_duty, done: 1, busy: 0, wrap: base};
      sb.push_back(e);
    end else begin
      for (int k = 1; k <= diff && k <= n_push; k++) begin
        e = '{duty: model_duty + dir * k, done: (k == diff) ? 1 : 0,
              busy: (k == diff) ? 0 : 1, wrap: base + k * SP};
        sb.push_back(e);
      end
    end
    n = (n_push < diff) ? n_push : diff;
    model_duty = model_duty + dir * n;
    tgt_valid = 1'b1;
    tgt_duty  = W'(target);
    @(negedge clk_in);
    #1;
    tgt_valid = 1'b0;
  endtask

  task automatic waitQueue(input int size, input int max_cycles, input string name);
    for (int i = 0; i < max_cycles && sb.size() > size; i++) @(negedge clk_in);
    #1;
    checkOutput(name, sb.size(), size);
    if (sb.size() > size) sb.delete();
  endtask

  initial begin
    int ps_seen;

    // Reset state
    repeat (10) @(negedge clk_in);
    #1;
    checkOutput("reset_duty", int'(duty_out), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_period_start", int'(period_start), 0);
    checkOutput("reset_tgt_ready", int'(tgt_ready), 1);
    rst    = 1'b1;
    enable = 1'b1;

    // Ramp up 0 -> 3: steps at wraps 2, 4, 6
    applyStimulus(3, 99);
    waitQueue(0, 300, "ramp_up_drain");

    // Ramp to 15, then down to 12 with a target offered mid-ramp
    applyStimulus(15, 99);
    waitQueue(0, 500, "ramp_to_15_drain");
    applyStimulus(12, 99);
    waitQueue(2, 100, "ramp_down_first_step");
    checkOutput("ramp_down_tgt_ready", int'(tgt_ready), 0);
    tgt_valid = 1'b1;
    tgt_duty  = 4'd0;
    repeat (3) begin
      @(negedge clk_in);
      #1;
      checkOutput("ramp_down_ready_held_low", int'(tgt_ready), 0);
    end
    tgt_valid = 1'b0;
    waitQueue(0, 200, "ramp_down_drain");

    // Equal target at duty 5
    applyStimulus(5, 99);
    waitQueue(0, 300, "ramp_to_5_drain");
    applyStimulus(5, 99);
    waitQueue(0, 10, "equal_target_drain");
    repeat (3) @(negedge clk_in);
    #1;
    checkOutput("equal_target_busy", int'(busy), 0);
    checkOutput("equal_target_duty", int'(duty_out), 5);

    // Freeze mid-ramp 5 -> 7
    applyStimulus(7, 99);
    repeat (20) @(negedge clk_in);
    #1;
    enable  = 1'b0;
    ps_seen = 0;
    repeat (40) begin
      @(negedge clk_in);
      if (period_start) ps_seen++;
    end
    #1;
    checkOutput("freeze_no_period_start", ps_seen, 0);
    checkOutput("freeze_duty_held", int'(duty_out), 5);
    checkOutput("freeze_busy_held", int'(busy), 1);
    checkOutput("freeze_tgt_ready", int'(tgt_ready), 0);
    enable = 1'b1;
    waitQueue(0, 200, "freeze_resume_drain");

    // Abort at duty 2 of a 0 -> 8 ramp
    applyStimulus(0, 99);
    waitQueue(0, 400, "ramp_to_0_drain");
    applyStimulus(8, 2);
    waitQueue(0, 200, "abort_ramp_drain");
    repeat (5) @(negedge clk_in);
    #1;
    abort = 1'b1;
    @(negedge clk_in);
    #1;
    abort = 1'b0;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_tgt_ready", int'(tgt_ready), 1);
    checkOutput("abort_duty", int'(duty_out), 2);
    checkOutput("abort_done", int'(done), 0);
    repeat (100) @(negedge clk_in);
    #1;
    checkOutput("abort_duty_stable", int'(duty_out), 2);

    // Reset asserted mid-ramp 2 -> 6, between clock edges
    applyStimulus(6, 1);
    waitQueue(0, 100, "reset_ramp_drain");
    repeat (4) @(negedge clk_in);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_reset_duty", int'(duty_out), 0);
    checkOutput("async_reset_busy", int'(busy), 0);
    checkOutput("async_reset_done", int'(done), 0);
    checkOutput("async_reset_tgt_ready", int'(tgt_ready), 1);
    model_duty = 0;
    repeat (3) @(negedge clk_in);
    #1;
    rst = 1'b1;
    repeat (80) @(negedge clk_in);
    #1;
    checkOutput("post_reset_duty", int'(duty_out), 0);
    checkOutput("post_reset_busy", int'(busy), 0);
    checkOutput("final_queue_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
